// File: rtl/dsp_post_adder_acc.sv
// DSP48A1-style post-adder/accumulator: X/Z operand muxes, 48-bit add/subtract with carry-in,
// and a falling-edge P register that feeds back for multiply-accumulate and drives the cascade.
module dsp_post_adder_acc #(
    parameter int unsigned P_WIDTH    = 48,
    parameter int unsigned M_WIDTH    = 36,
    parameter int unsigned PREG       = 1,
    parameter int unsigned CARRYINREG = 1,
    parameter              CARRYINSEL = "OPMODE5"
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CEP,
    input  logic               CECARRYIN,
    input  logic [7:0]         OPMODE,
    input  logic               CARRYIN,
    input  logic [M_WIDTH-1:0] M,
    input  logic [P_WIDTH-1:0] DAB,
    input  logic [P_WIDTH-1:0] C,
    input  logic [P_WIDTH-1:0] PCIN,
    output logic [P_WIDTH-1:0] P,
    output logic [P_WIDTH-1:0] PCOUT,
    output logic               CARRYOUT,
    output logic               CARRYOUTF
);

    localparam int unsigned S_WIDTH   = P_WIDTH + 1;
    localparam int unsigned EXT_WIDTH = P_WIDTH - M_WIDTH;
    localparam bit          USE_PORT  = (CARRYINSEL == "CARRYIN");

    logic [P_WIDTH-1:0] p_reg;
    logic               co_reg;
    logic [P_WIDTH-1:0] x_op;
    logic [P_WIDTH-1:0] z_op;
    logic               cin_src;
    logic               cin;
    logic [S_WIDTH-1:0] result;
    logic [P_WIDTH-1:0] sum;
    logic               co;

    // Parameter-dependent inputs and reserved OPMODE bits.
    logic unused_inputs;
    assign unused_inputs = ^{OPMODE[6], OPMODE[4], CARRYIN, CECARRYIN, OPMODE[5]};

    assign cin_src = USE_PORT ? CARRYIN : OPMODE[5];

    // Carry-in register keeps cin aligned with the M pipeline stage.
    generate
        if (CARRYINREG != 0) begin : g_cyi_reg
            logic cyi_reg;
            always_ff @(negedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    cyi_reg <= 1'b0;
                end else if (CECARRYIN) begin
                    cyi_reg <= cin_src;
                end
            end
            assign cin = cyi_reg;
        end else begin : g_cyi_direct
            assign cin = cin_src;
        end
    endgenerate

    // X operand select.
    always_comb begin
        x_op = '0;
        unique case (OPMODE[1:0])
            2'd0: x_op = '0;
            2'd1: x_op = {{EXT_WIDTH{1'b0}}, M};
            2'd2: x_op = p_reg;
            2'd3: x_op = DAB;
            default: x_op = '0;
        endcase
    end

    // Z operand select.
    always_comb begin
        z_op = '0;
        unique case (OPMODE[3:2])
            2'd0: z_op = '0;
            2'd1: z_op = PCIN;
            2'd2: z_op = p_reg;
            2'd3: z_op = C;
            default: z_op = '0;
        endcase
    end

    // 49-bit arithmetic; in subtract mode the top bit is the borrow.
    always_comb begin
        result = '0;
        if (OPMODE[7]) begin
            result = {1'b0, z_op} - ({1'b0, x_op} + S_WIDTH'(cin));
        end else begin
            result = {1'b0, z_op} + {1'b0, x_op} + S_WIDTH'(cin);
        end
    end

    assign sum = result[P_WIDTH-1:0];
    assign co  = result[P_WIDTH];

    // Feedback register clocks regardless of PREG so accumulation works either way.
    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_reg  <= '0;
            co_reg <= 1'b0;
        end else if (CEP) begin
            p_reg  <= sum;
            co_reg <= co;
        end
    end

    generate
        if (PREG != 0) begin : g_out_reg
            assign P        = p_reg;
            assign CARRYOUT = co_reg;
        end else begin : g_out_comb
            logic unused_co_reg;
            assign unused_co_reg = co_reg;
            assign P        = sum;
            assign CARRYOUT = co;
        end
    endgenerate

    assign PCOUT     = p_reg;
    assign CARRYOUTF = CARRYOUT;

endmodule
